// File: rtl/gb_cpu_bus_ctrl.sv
// CPU bus sequencer: single-byte reads/writes, 16-bit reads via TMP_L/TMP_H.
// Define GB_CPU_BUS_CTRL_WAIT_EN to stretch ACCESS until mem_ready; dst encoding is 4 bits, TMP_L=4'hA, TMP_H=4'hB.
module gb_cpu_bus_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   input  logic [3:0]  req_dst,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [3:0]  data_bus_req,
   output logic [7:0]  data_bus_data,
   output logic        data_bus_wren,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_READ8  = 2'b01,
      OP_WRITE8 = 2'b10,
      OP_READ16 = 2'b11
   } op_t;

   localparam logic [3:0] REG_TMP_L = 4'hA;
   localparam logic [3:0] REG_TMP_H = 4'hB;

   state_t     state, state_nxt;
   op_t        op_q;
   logic [3:0] dst_q;
   logic       hi_q;
   logic       accept;
   logic       access_done;

`ifdef GB_CPU_BUS_CTRL_WAIT_EN
   assign access_done = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign access_done      = 1'b1;
`endif

   assign req_ready = (state == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      data_bus_wren = 1'b0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept && op_t'(req_op) != OP_NOP) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_rd = (op_q != OP_WRITE8);
            mem_wr = (op_q == OP_WRITE8);
            if (access_done) state_nxt = (op_q == OP_WRITE8) ? IDLE : WB;
         end
         WB: begin
            data_bus_wren = 1'b1;
            // READ16 revisits ACCESS once for the high byte
            state_nxt = (op_q == OP_READ16 && !hi_q) ? ACCESS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q          <= OP_NOP;
         dst_q         <= '0;
         hi_q          <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         data_bus_data <= '0;
         data_bus_req  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q      <= op_t'(req_op);
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  dst_q     <= req_dst;
                  hi_q      <= 1'b0;
               end
            end
            ACCESS: begin
               if (access_done && op_q != OP_WRITE8) begin
                  data_bus_data <= mem_rdata;
                  if (op_q == OP_READ16) data_bus_req <= hi_q ? REG_TMP_H : REG_TMP_L;
                  else                   data_bus_req <= dst_q;
               end
            end
            WB: begin
               if (op_q == OP_READ16 && !hi_q) begin
                  hi_q     <= 1'b1;
                  mem_addr <= mem_addr + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/gb_cpu_bus_ctrl.md
GB_CPU_BUS_CTRL -- requirements
Module: gb_cpu_bus_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  machine clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  control unit requests a bus transaction.
REQ-004 SHALL have port: req_ready  output  1  block accepts request this cycle.
REQ-005 SHALL have port: req_op  input  2  00 NOP, 01 READ8, 10 WRITE8, 11 READ16.
REQ-006 SHALL have port: req_addr  input  16  transaction address.
REQ-007 SHALL have port: req_wdata  input  8  WRITE8 data.
REQ-008 SHALL have port: req_dst  input  regfile_r8_t  READ8 destination register.
REQ-009 SHALL have port: mem_addr  output  16  memory address.
REQ-010 SHALL have port: mem_rd / mem_wr  output  1 each  read / write strobe.
REQ-011 SHALL have port: mem_wdata  output  8; mem_rdata  input  8; mem_ready  input  1  access complete.
REQ-012 SHALL have port: data_bus_req  output  regfile_r8_t; data_bus_data  output  8; data_bus_wren  output  1  regfile write-back.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCESS, WB; req_ready = (state==IDLE) and not reset.
REQ-015 SHALL accept a request on a rising edge with req_valid && req_ready; latch op, addr, wdata, dst; NOP accepted, stays IDLE, no strobes.
REQ-016 SHALL in ACCESS drive mem_addr = latched address, mem_rd=1 for reads or mem_wr=1 with mem_wdata for WRITE8; never both strobes.
REQ-017 SHALL complete ACCESS on the edge where completion holds (REQ-027); read data sampled from mem_rdata on that edge.
REQ-018 SHALL on WRITE8 completion return to IDLE; no regfile write-back.
REQ-019 SHALL on READ8 completion enter WB for exactly one cycle: data_bus_wren=1, data_bus_req=latched dst, data_bus_data=sampled byte; then IDLE.
REQ-020 SHALL for READ16 read addr into REG_TMP_L (WB), then ACCESS at addr+1 (16-bit wrap, 0xFFFF->0x0000) into REG_TMP_H (WB), then IDLE; req_dst ignored.
REQ-021 SHALL give READ8 latency with zero wait: accept edge N, ACCESS cycle N+1, WB cycle N+2, req_ready high cycle N+3.
REQ-022 SHALL hold data_bus_wren, mem_rd, mem_wr low outside their states; data_bus_data/req hold last value when wren low.
REQ-023 SHALL ignore req_valid and input changes while busy; no request queueing.

Reset
REQ-024 SHALL on reset assertion immediately force state IDLE, mem_rd=0, mem_wr=0, data_bus_wren=0, busy=0, req_ready=0, mem_addr=0, mem_wdata=0, data_bus_data=0, data_bus_req all-zeros encoding.
REQ-025 SHALL abort any in-flight transaction on reset with no pending write-back; first accept possible on first rising edge after deassertion.

Configuration
REQ-026 SHALL support macro GB_CPU_BUS_CTRL_WAIT_EN selecting wait-state support.
REQ-027 SHALL with macro defined complete ACCESS only on an edge with mem_ready=1, holding strobes and address stable while mem_ready=0; without it complete ACCESS after exactly one cycle, mem_ready ignored.

Verification
REQ-028 SHALL cover READ8 addr 0xC000, dst REG_B, mem_rdata 0x5A, no wait -> one-cycle mem_rd at 0xC000, then one-cycle wren with REG_B/0x5A, ready 3 cycles after accept.
REQ-029 SHALL cover WRITE8 addr 0xFF80 wdata 0x3C -> one-cycle mem_wr at 0xFF80 with 0x3C, data_bus_wren never high.
REQ-030 SHALL cover READ16 addr 0xFFFF, rdata 0x34 then 0x12 -> wren REG_TMP_L/0x34, then mem_addr 0x0000, wren REG_TMP_H/0x12.
REQ-031 SHALL cover (WAIT_EN) READ8 with mem_ready low 3 cycles -> mem_rd held 4 cycles, address stable, single WB after.
REQ-032 SHALL cover reset asserted mid-ACCESS of READ16 -> strobes drop asynchronously, no WB, req_ready high first edge after release.
